// File: rtl/mem_copy_engine.sv
// mem_copy_engine: overlap-safe block copy (optional fill) over one memory port.
// Fill path compiled in only when MEM_COPY_FILL_EN is defined.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   Length,
  input  logic              Fill,
  input  logic [DATA_W-1:0] FillValue,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_back;

  logic [ADDR_W-1:0] w_diff;
  logic [ADDR_W-1:0] w_lenm1;
  logic              w_back;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_last;
  logic              w_fill_in;
  logic              w_fill;
  logic [DATA_W-1:0] w_wdata;

`ifdef MEM_COPY_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fval;

  assign w_fill_in = Fill;
  assign w_fill    = r_fill;
  assign w_wdata   = r_fill ? r_fval : r_hold;

  // Latch fill request alongside the transfer parameters
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_fill <= 1'b0;
      r_fval <= '0;
    end else if (r_state == S_IDLE && Start) begin
      r_fill <= Fill;
      r_fval <= FillValue;
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{Fill, FillValue};
  assign w_fill_in = 1'b0;
  assign w_fill    = 1'b0;
  assign w_wdata   = r_hold;
`endif

  // Backward when destination starts inside the source run
  assign w_diff    = DstAddr - SrcAddr;
  assign w_lenm1   = Length[ADDR_W-1:0] - A_ONE;
  assign w_back    = !w_fill_in && (w_diff != '0) &&
                     ({1'b0, w_diff} < Length);
  assign w_cnt_inc = r_cnt + C_ONE;
  assign w_last    = (w_cnt_inc == r_len);

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Length == '0)   w_next = S_DONE;
          else if (w_fill_in) w_next = S_WRITE;
          else                w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        if (w_last)      w_next = S_DONE;
        else if (w_fill) w_next = S_WRITE;
        else             w_next = S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pointers, count and hold register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_back <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt  <= '0;
            r_len  <= Length;
            r_back <= w_back;
            r_src  <= w_back ? SrcAddr + w_lenm1 : SrcAddr;
            r_dst  <= w_back ? DstAddr + w_lenm1 : DstAddr;
          end
        end
        S_READ:  r_hold <= MemRData;
        S_WRITE: begin
          r_cnt <= w_cnt_inc;
          r_src <= r_back ? r_src - A_ONE : r_src + A_ONE;
          r_dst <= r_back ? r_dst - A_ONE : r_dst + A_ONE;
        end
        default: ;
      endcase
    end
  end

  // Memory port and status decoded from registers only
  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    MemAddr  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemWData = '0;
    unique case (r_state)
      S_READ: begin
        Busy    = 1'b1;
        MemAddr = r_src;
        MemRead = 1'b1;
      end
      S_WRITE: begin
        Busy     = 1'b1;
        MemAddr  = r_dst;
        MemWrite = 1'b1;
        MemWData = w_wdata;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Count = r_cnt;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed + random transfers against a byte-level model.
// Fill expectations follow MEM_COPY_FILL_EN.
module tb_mem_copy_engine;

`ifdef MEM_COPY_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] SrcAddr = '0;
  logic [7:0] DstAddr = '0;
  logic [8:0] Length = '0;
  logic       Fill = 1'b0;
  logic [7:0] FillValue = '0;
  logic       Busy, Done, MemRead, MemWrite;
  logic [8:0] Count;
  logic [7:0] MemAddr, MemWData, MemRData;

  logic [7:0]  mem  [256];
  logic [7:0]  refm [256];
  logic [16:0] q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          first_wr = -1;
  bit          mon_on = 1'b0;

  mem_copy_engine dut (
    .CLK(CLK), .reset(reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .Fill(Fill), .FillValue(FillValue),
    .Busy(Busy), .Done(Done), .Count(Count),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 CLK = ~CLK;

  assign MemRData = MemRead ? mem[MemAddr] : 8'h00;

  always @(posedge CLK)
    if (MemWrite) mem[MemAddr] <= MemWData;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int m = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== refm[i]) m++;
    chk(tag, m, 0);
  endtask

  // Every memory access must match the next expected one
  always @(negedge CLK) begin
    if (mon_on && (MemRead || MemWrite)) begin
      logic [16:0] obs;
      obs = {MemWrite, MemAddr, MemWrite ? MemWData : 8'h00};
      chk("rw_exclusive", {31'd0, MemRead & MemWrite}, 0);
      if (q.size() == 0) begin
        chk("unexpected_access", q.size(), 1);
      end else begin
        chk("access", obs, q.pop_front());
        if (MemWrite && first_wr < 0) first_wr = int'(MemAddr);
      end
    end
  end

  // Sequential byte-at-a-time reference; writes applied for i < lim
  task automatic model(input logic [7:0] s, input logic [7:0] d,
                       input int n, input logic f, input logic [7:0] fv,
                       input int lim);
    bit ef;
    bit back;
    logic [7:0] diff, sp, dp, v;
    ef   = f && FILL_EN;
    diff = 8'(d - s);
    back = !ef && diff != 0 && int'(diff) < n;
    for (int i = 0; i < n; i++) begin
      sp = back ? 8'(s + n - 1 - i) : 8'(s + i);
      dp = back ? 8'(d + n - 1 - i) : 8'(d + i);
      if (ef) begin
        v = fv;
      end else begin
        v = refm[sp];
        q.push_back({1'b0, sp, 8'h00});
      end
      q.push_back({1'b1, dp, v});
      if (i < lim) refm[dp] = v;
    end
  endtask

  task automatic xfer(input logic [7:0] s, input logic [7:0] d,
                      input int n, input logic f, input logic [7:0] fv,
                      input bit poke);
    int lat, busy, exp_lat;
    model(s, d, n, f, fv, n);
    exp_lat  = (n == 0) ? 1 : (f && FILL_EN) ? n + 1 : 2 * n + 1;
    first_wr = -1;
    @(negedge CLK);
    Start = 1'b1; SrcAddr = s; DstAddr = d;
    Length = 9'(n); Fill = f; FillValue = fv;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    SrcAddr = 8'($urandom); DstAddr = 8'($urandom);
    Length = 9'($urandom); Fill = 1'($urandom); FillValue = 8'($urandom);
    lat = -1;
    busy = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge CLK);
      if (poke && c == 3) Start = 1'b1;
      if (poke && c == 4) Start = 1'b0;
      if (Busy) busy++;
      if (Done) begin
        lat = c;
        break;
      end
    end
    Start = 1'b0;
    chk("done_latency", lat, exp_lat);
    chk("busy_cycles", busy, exp_lat - 1);
    chk("count", {23'd0, Count}, n);
    chk("done_port_idle", {MemAddr, MemWData, MemRead, MemWrite}, 0);
    chk("trace_left", q.size(), 0);
    q.delete();
    chk_mem("mem_contents");
  endtask

  initial begin
    logic [7:0] orig [4];
    logic [7:0] s, d;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'($urandom);
      refm[i] = mem[i];
    end
    repeat (2) @(negedge CLK);
    chk("reset_outputs",
        {Busy, Done, Count, MemAddr, MemRead, MemWrite, MemWData}, 0);
    reset  = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i]  = 8'(i + 1);
      refm[8'h10 + i] = 8'(i + 1);
    end
    xfer(8'h10, 8'h40, 4, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("fwd_dst", mem[8'h40 + i], i + 1);

    for (int i = 0; i < 5; i++) begin
      mem[8'h20 + i]  = 8'(8'hA + i);
      refm[8'h20 + i] = 8'(8'hA + i);
    end
    xfer(8'h20, 8'h22, 5, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++)
      chk("bwd_dst", mem[8'h22 + i], 8'hA + i);
    chk("bwd_first_wr", first_wr, 8'h26);

    for (int i = 0; i < 4; i++) orig[i] = mem[8'(8'hFE + i)];
    xfer(8'hFE, 8'h01, 4, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("wrap_dst", mem[8'h01 + i], orig[i]);

    xfer(8'h00, 8'h80, 256, 1'b0, 8'h00, 1'b0);
    xfer(8'h33, 8'h44, 0, 1'b0, 8'h00, 1'b0);
    xfer(8'h60, 8'hA0, 6, 1'b0, 8'h00, 1'b1);
    xfer(8'h70, 8'h70, 3, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) orig[i] = mem[i];
    xfer(8'h00, 8'h30, 3, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++)
      chk("fill_dst", mem[8'h30 + i], FILL_EN ? 8'hAA : orig[i]);

    model(8'h50, 8'h90, 8, 1'b0, 8'h00, 3);
    @(negedge CLK);
    Start = 1'b1; SrcAddr = 8'h50; DstAddr = 8'h90;
    Length = 9'd8; Fill = 1'b0;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (7) @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("reset_mid_outputs",
        {Busy, Done, Count, MemAddr, MemRead, MemWrite, MemWData}, 0);
    q.delete();
    @(negedge CLK);
    chk_mem("reset_mid_mem");
    reset = 1'b1;
    xfer(8'h50, 8'h90, 8, 1'b0, 8'h00, 1'b0);

    for (int t = 0; t < 12; t++) begin
      s = 8'($urandom);
      d = ($urandom_range(0, 1) == 1) ? 8'(s + $urandom_range(0, 10))
                                      : 8'($urandom);
      n = int'($urandom_range(1, 40));
      xfer(s, d, n, $urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
